// File: rtl/alu_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_pipe_if                                              |
// | Description : Operation/result handshake bundle for alu_pipe.          |
// |               Request side: in_valid, in_ready, a, b, func.            |
// |               Response side: out_valid, out_ready, result, flags.      |
// |               master = operation producer / result consumer.           |
// |               slave  = the ALU.                                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface alu_pipe_if #(
  parameter int n = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [3:0]   func;
  logic [n-1:0] result;
  logic [3:0]   flags;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, a, b, func, out_ready,
    input  in_ready, result, flags, out_valid
  );

  modport slave (
    input  in_valid, a, b, func, out_ready,
    output in_ready, result, flags, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_pipe                                                 |
// | Description : Single-stage ALU with valid/ready handshakes and an      |
// |               optional iterative shift-add multiplier.                 |
// |               Opcodes 0-9 complete with latency 1; RMUL (10) takes     |
// |               n+1 cycles when built. Flags = {V, C, N, Z}.             |
// | Ports       : clk   - clock, rising edge                               |
// |               reset - synchronous active-high reset                    |
// |               bus   - alu_pipe_if.slave (in_valid/in_ready/a/b/func,   |
// |                       out_valid/out_ready/result/flags)                |
// | Config      : define ALU_PIPE_MUL_EN to build the multiplier; without  |
// |               it func 10 is handled as a reserved opcode.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module alu_pipe #(
  parameter int n  = 8,
  parameter int SW = $clog2(n)
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] c_OP_RA   = 4'd0;
  localparam logic [3:0] c_OP_RB   = 4'd1;
  localparam logic [3:0] c_OP_RADD = 4'd2;
  localparam logic [3:0] c_OP_RSUB = 4'd3;
  localparam logic [3:0] c_OP_RAND = 4'd4;
  localparam logic [3:0] c_OP_ROR  = 4'd5;
  localparam logic [3:0] c_OP_RXOR = 4'd6;
  localparam logic [3:0] c_OP_RNOR = 4'd7;
  localparam logic [3:0] c_OP_RSHL = 4'd8;
  localparam logic [3:0] c_OP_RSHR = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] result_q;
  logic [3:0]   flags_q;
  logic         out_valid_q;

  logic         w_in_ready;
  logic         w_accept;
  logic         w_is_mul;
  logic         w_mul_fin;
  logic [n-1:0] w_mul_res;
  logic [3:0]   w_mul_flags;

  // Held off during reset; otherwise open in IDLE whenever the output slot
  // is empty or being drained this very cycle.
  assign w_in_ready = !reset && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  logic [SW-1:0] w_sh;
  logic [n:0]    w_sum;
  logic [n:0]    w_diff;
  logic [n:0]    w_shl;
  logic [n:0]    w_shr;
  logic [n-1:0]  w_alu_res;
  logic          w_alu_c;
  logic          w_alu_v;
  logic [3:0]    w_alu_flags;

  assign w_sh   = bus.b[SW-1:0];
  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  // MSB of the widened difference is the borrow (a < b unsigned).
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
  // One guard bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign w_shl  = {1'b0, bus.a} << w_sh;
  assign w_shr  = {bus.a, 1'b0} >> w_sh;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.func)
      c_OP_RA:   w_alu_res = bus.a;
      c_OP_RB:   w_alu_res = bus.b;
      c_OP_RADD: begin
        w_alu_res = w_sum[n-1:0];
        w_alu_c   = w_sum[n];
        w_alu_v   = (bus.a[n-1] == bus.b[n-1]) && (w_sum[n-1] != bus.a[n-1]);
      end
      c_OP_RSUB: begin
        w_alu_res = w_diff[n-1:0];
        w_alu_c   = w_diff[n];
        w_alu_v   = (bus.a[n-1] != bus.b[n-1]) && (w_diff[n-1] != bus.a[n-1]);
      end
      c_OP_RAND: w_alu_res = bus.a & bus.b;
      c_OP_ROR:  w_alu_res = bus.a | bus.b;
      c_OP_RXOR: w_alu_res = bus.a ^ bus.b;
      c_OP_RNOR: w_alu_res = ~(bus.a | bus.b);
      c_OP_RSHL: begin
        w_alu_res = w_shl[n-1:0];
        w_alu_c   = w_shl[n];
      end
      c_OP_RSHR: begin
        w_alu_res = w_shr[n:1];
        w_alu_c   = w_shr[0];
      end
      default: ; // reserved: all zero, Z comes out as 1
    endcase
  end

  assign w_alu_flags = {w_alu_v, w_alu_c, w_alu_res[n-1], ~|w_alu_res};

  // ---------------------------------------------------------------------
  // Optional shift-add multiplier
  // ---------------------------------------------------------------------
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] c_OP_RMUL = 4'd10;
  localparam int         CW        = $clog2(n + 1);

  logic [2*n-1:0] mul_acc_q;
  logic [2*n-1:0] mul_mcand_q;
  logic [n-1:0]   mul_mplier_q;
  logic [CW-1:0]  mul_cnt_q;

  assign w_is_mul    = (bus.func == c_OP_RMUL);
  // After n iterations the MUL state spends one more cycle publishing the
  // product, which places out_valid n+1 cycles after acceptance.
  assign w_mul_fin   = (state_q == S_MUL) && (mul_cnt_q == CW'(n));
  assign w_mul_res   = mul_acc_q[n-1:0];
  assign w_mul_flags = {1'b0, |mul_acc_q[2*n-1:n], mul_acc_q[n-1], ~|mul_acc_q[n-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
    end else if (w_accept && w_is_mul) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= {{n{1'b0}}, bus.a};
      mul_mplier_q <= bus.b;
      mul_cnt_q    <= '0;
    end else if ((state_q == S_MUL) && !w_mul_fin) begin
      mul_acc_q    <= mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
      mul_mcand_q  <= mul_mcand_q << 1;
      mul_mplier_q <= mul_mplier_q >> 1;
      mul_cnt_q    <= mul_cnt_q + CW'(1);
    end
  end
`else
  assign w_is_mul    = 1'b0;
  assign w_mul_fin   = 1'b0;
  assign w_mul_res   = '0;
  assign w_mul_flags = 4'd0;
`endif

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept && w_is_mul) state_d = S_MUL;
      S_MUL:   if (w_mul_fin) state_d = S_DONE;
      S_DONE:  if (out_valid_q && bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      flags_q     <= 4'd0;
      out_valid_q <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      // Overwrites the old result in the same cycle it is drained.
      result_q    <= w_alu_res;
      flags_q     <= w_alu_flags;
      out_valid_q <= 1'b1;
    end else if (w_mul_fin) begin
      result_q    <= w_mul_res;
      flags_q     <= w_mul_flags;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_alu_pipe                                              |
// | Description : Self-checking bench for alu_pipe (n=8): directed vector  |
// |               table, hand-written stall/multiply/reset sequences and a |
// |               randomized run against a transaction-level model.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_alu_pipe;

  localparam int N = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_pipe_if #(.n(N)) bus ();

  alu_pipe #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl; // {V, C, N, Z}
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [3:0] f, input logic [7:0] av,
                       input logic [7:0] bv, input logic orr);
    bus.in_valid  = iv;
    bus.func      = f;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = orr;
  endtask

  // Reference ALU built from the arithmetic definitions; returns {result, V, C, N, Z}.
  function automatic logic [11:0] ref_op(input int f, input int av, input int bv);
    int r, c, v, sa, sb, t, s;
    r = 0; c = 0; v = 0;
    sa = (av >= 128) ? av - 256 : av;
    sb = (bv >= 128) ? bv - 256 : bv;
    s  = bv % 8;
    case (f)
      0: r = av;
      1: r = bv;
      2: begin
        t = av + bv; r = t % 256; c = (t > 255) ? 1 : 0;
        t = sa + sb; v = (t > 127 || t < -128) ? 1 : 0;
      end
      3: begin
        t = av - bv; r = (t + 256) % 256; c = (av < bv) ? 1 : 0;
        t = sa - sb; v = (t > 127 || t < -128) ? 1 : 0;
      end
      4: r = av & bv;
      5: r = av | bv;
      6: r = av ^ bv;
      7: r = 255 - (av | bv);
      8: begin
        t = av * (1 << s); r = t % 256;
        c = (s != 0 && ((t / 256) % 2) == 1) ? 1 : 0;
      end
      9: begin
        r = av / (1 << s);
        c = (s != 0 && ((av / (1 << (s - 1))) % 2) == 1) ? 1 : 0;
      end
`ifdef ALU_PIPE_MUL_EN
      10: begin
        t = av * bv; r = t % 256; c = (t > 255) ? 1 : 0;
      end
`endif
      default: ;
    endcase
    return {r[7:0], v[0], c[0], r[7], (r == 0) ? 1'b1 : 1'b0};
  endfunction

  // Random-phase model state
  logic        m_valid;
  logic        m_from_mul;
  int          m_mul_left;
  logic [11:0] m_out;
  logic [11:0] m_mul_out;

  initial begin
    checks   = 0;
    failures = 0;

    vt[0]  = '{4'd2,  8'h7F, 8'h01, 8'h80, 4'b1010}; // RADD signed overflow
    vt[1]  = '{4'd3,  8'h05, 8'h07, 8'hFE, 4'b0110}; // RSUB borrow
    vt[2]  = '{4'd3,  8'h33, 8'h33, 8'h00, 4'b0001}; // RSUB zero
    vt[3]  = '{4'd8,  8'h81, 8'h01, 8'h02, 4'b0100}; // RSHL carry out
    vt[4]  = '{4'd9,  8'h81, 8'h01, 8'h40, 4'b0100}; // RSHR carry out
    vt[5]  = '{4'd1,  8'h00, 8'hA5, 8'hA5, 4'b0010}; // RB
    vt[6]  = '{4'd0,  8'h00, 8'hFF, 8'h00, 4'b0001}; // RA zero
    vt[7]  = '{4'd4,  8'hF0, 8'h3C, 8'h30, 4'b0000}; // RAND
    vt[8]  = '{4'd5,  8'hF0, 8'h0C, 8'hFC, 4'b0010}; // ROR
    vt[9]  = '{4'd6,  8'hFF, 8'hFF, 8'h00, 4'b0001}; // RXOR
    vt[10] = '{4'd7,  8'h00, 8'h00, 8'hFF, 4'b0010}; // RNOR
    vt[11] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 4'b0001}; // reserved
    vt[12] = '{4'd2,  8'hFF, 8'h01, 8'h00, 4'b0101}; // RADD carry, zero
    vt[13] = '{4'd3,  8'h80, 8'h01, 8'h7F, 4'b1000}; // RSUB signed overflow
    vt[14] = '{4'd8,  8'hFF, 8'h00, 8'hFF, 4'b0010}; // RSHL by 0: C=0
    vt[15] = '{4'd9,  8'hC0, 8'h0F, 8'h01, 4'b0100}; // RSHR by 7 (b[2:0])

    // ---- reset ----
    reset = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result), 32'd0);
    chk("rst_flags",     32'(bus.flags), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ---- directed table, back-to-back with out_ready=1 ----
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vt[i].f, vt[i].a, vt[i].b, 1'b1);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      step();
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("tbl%0d_result", i), 32'(bus.result), 32'(vt[i].res));
      chk($sformatf("tbl%0d_flags", i), 32'(bus.flags), 32'(vt[i].fl));
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
    step();
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // ---- stall: RSHL held while out_ready=0 ----
    drive(1'b1, 4'd8, 8'h81, 8'h01, 1'b0);
    step();
    drive(1'b1, 4'd0, 8'h11, 8'h00, 1'b0); // pending RA, must wait
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_valid",    32'(bus.out_valid), 32'd1);
      chk("stall_result",   32'(bus.result), 32'h02);
      chk("stall_flags",    32'(bus.flags), 32'b0100);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("replace_valid",  32'(bus.out_valid), 32'd1);
    chk("replace_result", 32'(bus.result), 32'h11);
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
    step();

    // ---- RMUL 20 * 13 = 260 ----
    drive(1'b1, 4'd10, 8'd20, 8'd13, 1'b1);
    step();
    bus.in_valid = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    begin
      int edges;
      edges = 0;
      while (!bus.out_valid && edges < 40) begin
        chk("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        edges++;
      end
      chk("mul_latency", 32'(edges), 32'd9);
      chk("mul_result",  32'(bus.result), 32'h04);
      chk("mul_flags",   32'(bus.flags), 32'b0100);
      chk("mul_done_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("mul_drained_valid", 32'(bus.out_valid), 32'd0);
      chk("mul_idle_in_ready", 32'(bus.in_ready), 32'd1);
    end
`else
    chk("mul_off_valid",  32'(bus.out_valid), 32'd1);
    chk("mul_off_result", 32'(bus.result), 32'h00);
    chk("mul_off_flags",  32'(bus.flags), 32'b0001);
    step();
`endif

    // ---- reset on cycle 4 of an RMUL ----
    drive(1'b1, 4'd10, 8'd200, 8'd201, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_in_ready",  32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("mrst_idle_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 4'd1, 8'h00, 8'hA5, 1'b1);
    step();
    chk("mrst_rb_valid",  32'(bus.out_valid), 32'd1);
    chk("mrst_rb_result", 32'(bus.result), 32'hA5);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // ---- randomized run against transaction model ----
    m_valid    = 1'b0;
    m_from_mul = 1'b0;
    m_mul_left = 0;
    m_out      = '0;
    m_mul_out  = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic iv, orr, m_ready, acc;
      logic [3:0] f;
      logic [7:0] av, bv;
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_result", 32'(bus.result), 32'(m_out[11:4]));
        chk("rnd_flags",  32'(bus.flags), 32'(m_out[3:0]));
      end
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      f   = 4'($urandom_range(0, 15));
      av  = 8'($urandom);
      bv  = 8'($urandom);
      drive(iv, f, av, bv, orr);
      #1;
      m_ready = (m_mul_left == 0) && !(m_valid && m_from_mul) && (!m_valid || orr);
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(m_ready));
      acc = iv && m_ready;
`ifdef ALU_PIPE_MUL_EN
      if (acc && f == 4'd10) begin
        m_mul_left = N + 1;
        m_mul_out  = ref_op(int'(f), int'(av), int'(bv));
        m_valid    = 1'b0;
        m_from_mul = 1'b0;
      end else
`endif
      if (acc) begin
        m_out      = ref_op(int'(f), int'(av), int'(bv));
        m_valid    = 1'b1;
        m_from_mul = 1'b0;
      end else if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_out      = m_mul_out;
          m_valid    = 1'b1;
          m_from_mul = 1'b1;
        end
      end else if (orr) begin
        m_valid    = 1'b0;
        m_from_mul = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The module SHALL take parameter n, default 8, giving the operand and result width in bits (n >= 4).
REQ-002 The module SHALL take parameter SW, default $clog2(n), giving the shift-amount width taken from b[SW-1:0].
REQ-003 clk  input  1  the single clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the operation on a, b and func is valid this cycle.
REQ-006 in_ready  output  1  the block accepts an operation this cycle.
REQ-007 a  input  n  operand A.
REQ-008 b  input  n  operand B.
REQ-009 func  input  4  opcode: 0 RA, 1 RB, 2 RADD, 3 RSUB, 4 RAND, 5 ROR, 6 RXOR, 7 RNOR, 8 RSHL, 9 RSHR, 10 RMUL, 11-15 reserved.
REQ-010 result  output  n  the registered result.
REQ-011 flags  output  4  the registered flags: [0] Z (result zero), [1] N (result[n-1]), [2] C carry/borrow/overflow-out, [3] V signed overflow.
REQ-012 out_valid  output  1  result and flags are valid.
REQ-013 out_ready  input  1  the consumer takes the result this cycle.

Function
REQ-014 An operation SHALL be accepted on a cycle where in_valid and in_ready are both 1; a, b and func SHALL be captured on that edge.
REQ-015 in_ready SHALL be 1 when state is IDLE and either out_valid is 0 or out_ready is 1, so that single-cycle operations can issue back-to-back.
REQ-016 Opcodes 0-9 SHALL produce result, flags and out_valid=1 on the edge after acceptance, giving a latency of 1.
REQ-017 RADD SHALL set result to (a+b) mod 2^n, C to the carry out of bit n-1, and V to signed two's-complement overflow.
REQ-018 RSUB SHALL set result to (a-b) mod 2^n, C to 1 when a < b unsigned (borrow), and V to signed overflow.
REQ-019 RSHL/RSHR SHALL perform a logical shift of a by b[SW-1:0], with C set to the last bit shifted out (0 when the shift amount is 0).
REQ-020 RA, RB, RAND, ROR, RXOR and RNOR SHALL clear C and V.
REQ-021 Reserved opcodes SHALL give result 0, flags Z=1 and C=V=N=0, with latency 1.
REQ-022 The state machine SHALL have three states, IDLE, MUL and DONE: IDLE goes to MUL on acceptance of RMUL; MUL runs n shift-add iterations, one per cycle; MUL then goes to DONE; DONE goes to IDLE when out_valid and out_ready are both 1.
REQ-023 RMUL SHALL give result equal to the low n bits of the unsigned product a*b, with C=1 if the high n bits are nonzero and V=0, and out_valid SHALL assert n+1 cycles after acceptance.
REQ-024 out_valid SHALL stay 1 and result and flags SHALL stay unchanged until the cycle in which out_ready is 1.
REQ-025 If out_ready is 1 and a new operation is accepted in the same cycle, the new result SHALL replace the old one with no bubble.
REQ-026 In MUL and DONE, in_ready SHALL be 0.

Reset
REQ-027 When reset is 1 at a clock edge: state goes to IDLE; out_valid, result and flags go to 0; any RMUL in progress is abandoned with no output.
REQ-028 in_ready SHALL be 0 while reset is 1 and SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-029 With macro ALU_PIPE_MUL_EN defined, the MUL/DONE datapath SHALL be built and RMUL SHALL behave as REQ-022 to REQ-023.
REQ-030 Without ALU_PIPE_MUL_EN, no multiplier logic SHALL be built, the FSM SHALL stay in IDLE, and func 10 SHALL be treated as reserved (REQ-021).

Verification (n=8)
REQ-031 RADD with a=8'h7F, b=8'h01 -> one cycle later result=8'h80, flags N=1 V=1 C=0 Z=0.
REQ-032 RSUB with a=8'h05, b=8'h07 -> result=8'hFE, C=1, N=1, V=0; RSUB with a=b=8'h33 -> result=8'h00, Z=1.
REQ-033 RMUL with a=8'd20, b=8'd13, out_ready=1 (ALU_PIPE_MUL_EN defined) -> in_ready=0 for 9 cycles, then result=8'h04 with C=1 (260); without the macro -> result=0, Z=1 after 1 cycle.
REQ-034 Back-to-back: RAND, ROR and RXOR on 3 consecutive cycles with out_ready=1 -> out_valid high for 3 consecutive cycles, each result correct.
REQ-035 Stall: out_ready=0 after RSHL a=8'h81, b=8'd1 -> result=8'h02 and C=1 held, in_ready=0; releasing out_ready -> in_ready returns to 1 in the same cycle.
REQ-036 Reset asserted on cycle 4 of an RMUL -> next cycle out_valid=0 and state IDLE; a following RB with b=8'hA5 -> result=8'hA5.
